// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, fetches instruction words over req/ack and presents them to the decoder.
// Needs at least 2 cycles per instruction; stall_in holds the instruction; a missing ack or a misaligned redirect makes fetch_err stick until reset.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned MAX_WAIT = 15,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   output logic             imem_req,
   output logic [31:0]      imem_addr,
   input  logic             imem_ack,
   input  logic [31:0]      imem_rdata,
   input  logic             stall_in,
   input  logic             redirect,
   input  logic [31:0]      redirect_target,
   output logic [31:0]      pc,
   output logic [31:0]      instr,
   output logic [6:0]       op,
   output logic             instr_valid,
   output logic             fetch_err,
   output logic [CNT_W-1:0] retire_count
);

   localparam logic [31:0] NOP       = 32'h0000_0013;
   localparam logic [7:0]  WAIT_LAST = 8'(MAX_WAIT - 1);

   typedef enum logic [1:0] {IDLE, REQ, HOLD, ERR} state_t;

   state_t           state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [31:0]      instr_q, instr_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;
   logic             req_q, req_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       wait_q, wait_d;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      wait_d  = wait_q;
      case (state_q)
         IDLE: state_d = REQ;
         REQ: begin
            // An ack on the last allowed cycle still wins over the timeout.
            if (imem_ack) begin
               instr_d = imem_rdata;
               valid_d = 1'b1;
               wait_d  = 8'd0;
               state_d = HOLD;
            end else if (wait_q == WAIT_LAST) begin
               wait_d  = 8'd0;
               err_d   = 1'b1;
               state_d = ERR;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         HOLD: begin
            if (!stall_in) begin
               valid_d = 1'b0;
               instr_d = NOP;
               if (redirect && (redirect_target[1:0] != 2'b00)) begin
                  err_d   = 1'b1;
                  state_d = ERR;
               end else begin
                  pc_d    = redirect ? redirect_target : pc_q + 32'd4;
                  cnt_d   = cnt_q + CNT_W'(1);
                  state_d = REQ;
               end
            end
         end
         default: begin
            err_d   = 1'b1;
            valid_d = 1'b0;
            instr_d = NOP;
            state_d = ERR;
         end
      endcase
      req_d = (state_d == REQ);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         instr_q <= NOP;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         req_q   <= 1'b0;
         cnt_q   <= '0;
         wait_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         req_q   <= req_d;
         cnt_q   <= cnt_d;
         wait_q  <= wait_d;
      end
   end

   assign imem_req     = req_q;
   assign imem_addr    = pc_q;
   assign pc           = pc_q;
   assign instr        = instr_q;
   assign op           = instr_q[6:0];
   assign instr_valid  = valid_q;
   assign fetch_err    = err_q;
   assign retire_count = cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: a driver pushes expected fetches into a queue, a monitor checks them.
module tb_instr_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          MAX_WAIT = 6;
   localparam int          CNT_W    = 4;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic             clk = 1'b0;
   logic             reset;
   logic             imem_req;
   logic [31:0]      imem_addr;
   logic             imem_ack;
   logic [31:0]      imem_rdata;
   logic             stall_in;
   logic             redirect;
   logic [31:0]      redirect_target;
   logic [31:0]      pc;
   logic [31:0]      instr;
   logic [6:0]       op;
   logic             instr_valid;
   logic             fetch_err;
   logic [CNT_W-1:0] retire_count;

   instr_fetch_unit #(.RESET_PC(RESET_PC), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .stall_in(stall_in), .redirect(redirect), .redirect_target(redirect_target),
      .pc(pc), .instr(instr), .op(op), .instr_valid(instr_valid),
      .fetch_err(fetch_err), .retire_count(retire_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
      int          cnt;
   } exp_t;

   exp_t        sb[$];
   exp_t        cur;
   bit          have = 1'b0;
   int          errors = 0;
   int          checks = 0;
   logic [31:0] m_pc;
   int          m_cnt;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, got, exp);
      end
   endtask

   // Monitor: whenever an instruction is presented it must match the next expected fetch.
   initial forever begin
      @(negedge clk);
      if (reset) begin
         have = 1'b0;
      end else if (instr_valid) begin
         if (!have) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL sb_underflow: instr_valid=1 with no expected fetch outstanding");
            end else begin
               cur  = sb.pop_front();
               have = 1'b1;
            end
         end
         if (have) begin
            check("sb_pc", pc, cur.pc);
            check("sb_instr", instr, cur.data);
            check("sb_op", {25'd0, op}, {25'd0, cur.data[6:0]});
            check("sb_count", 32'(retire_count), 32'(cur.cnt % (1 << CNT_W)));
            check("sb_req_low", {31'd0, imem_req}, 32'd0);
            check("sb_err_low", {31'd0, fetch_err}, 32'd0);
         end
      end else begin
         have = 1'b0;
         check("nop_when_invalid", instr, NOP);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   task automatic do_reset();
      reset = 1'b1; imem_ack = 1'b0; stall_in = 1'b0; redirect = 1'b0;
      @(negedge clk);
      check("rst_pc", pc, RESET_PC);
      check("rst_addr", imem_addr, RESET_PC);
      check("rst_instr", instr, NOP);
      check("rst_valid", {31'd0, instr_valid}, 32'd0);
      check("rst_err", {31'd0, fetch_err}, 32'd0);
      check("rst_req", {31'd0, imem_req}, 32'd0);
      check("rst_count", 32'(retire_count), 32'd0);
      sb.delete();
      m_pc = RESET_PC;
      m_cnt = 0;
      reset = 1'b0;
   endtask

   task automatic wait_req(output bit ok);
      int t = 0;
      while (imem_req !== 1'b1 && t < 20) begin
         @(negedge clk);
         t++;
      end
      ok = (t < 20);
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL req_timeout: imem_req=%b required 1", imem_req);
      end else begin
         check("imem_addr", imem_addr, m_pc);
      end
   endtask

   // d cycles without ack, then ack with data.
   task automatic issue(input int d, input logic [31:0] data);
      bit ok;
      wait_req(ok);
      if (ok) begin
         imem_ack = 1'b0;
         repeat (d) @(negedge clk);
         check("req_while_waiting", {31'd0, imem_req}, 32'd1);
         imem_ack = 1'b1;
         imem_rdata = data;
         sb.push_back('{pc: m_pc, data: data, cnt: m_cnt});
         @(negedge clk);
         imem_ack = 1'b0;
         imem_rdata = $urandom;
         check("valid_after_ack", {31'd0, instr_valid}, 32'd1);
      end
   endtask

   // s stalled cycles with ignored redirect noise, then retire.
   task automatic retire(input int s, input bit redir, input logic [31:0] tgt);
      for (int i = 0; i < s; i++) begin
         stall_in = 1'b1;
         redirect = 1'($urandom_range(0, 1));
         redirect_target = $urandom;
         @(negedge clk);
      end
      stall_in = 1'b0;
      redirect = redir;
      redirect_target = tgt;
      @(negedge clk);
      redirect = 1'b0;
      m_cnt++;
      m_pc = redir ? tgt : m_pc + 32'd4;
      check("req_after_retire", {31'd0, imem_req}, 32'd1);
      check("pc_after_retire", pc, m_pc);
   endtask

   task automatic rand_fetch();
      bit redir;
      redir = ($urandom_range(0, 3) == 0);
      issue($urandom_range(0, MAX_WAIT - 1), $urandom);
      retire($urandom_range(0, 3), redir, $urandom & 32'hFFFF_FFFC);
   endtask

   initial begin
      bit ok;
      reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
      stall_in = 1'b0; redirect = 1'b0; redirect_target = '0;
      @(negedge clk);
      do_reset();

      // Back-to-back fetches with ack every REQ cycle
      for (int i = 0; i < 3; i++) begin
         issue(0, 32'h0050_0093);
         retire(0, 1'b0, 32'h0);
      end
      check("t1_count", 32'(retire_count), 32'd3);

      // Long stall with ignored redirect noise, then redirect on retire
      issue(1, $urandom);
      retire(5, 1'b0, 32'h0);
      issue(0, $urandom);
      retire(2, 1'b1, 32'h0000_0100);
      issue(0, $urandom);
      retire(0, 1'b0, 32'h0);

      // Ack on the last allowed REQ cycle
      issue(MAX_WAIT - 1, $urandom);
      retire(1, 1'b0, 32'h0);

      // PC wrap at the top of the address space
      issue(0, $urandom);
      retire(0, 1'b1, 32'hFFFF_FFFC);
      issue(2, $urandom);
      retire(0, 1'b0, 32'h0);
      check("pc_wrap", m_pc, 32'h0);
      issue(0, $urandom);
      retire(0, 1'b0, 32'h0);

      // Fetch timeout
      wait_req(ok);
      imem_ack = 1'b0;
      repeat (MAX_WAIT - 1) @(negedge clk);
      check("to_req_before", {31'd0, imem_req}, 32'd1);
      check("to_err_before", {31'd0, fetch_err}, 32'd0);
      @(negedge clk);
      check("to_err", {31'd0, fetch_err}, 32'd1);
      check("to_req", {31'd0, imem_req}, 32'd0);
      check("to_instr", instr, NOP);
      imem_ack = 1'b1;
      repeat (3) @(negedge clk);
      imem_ack = 1'b0;
      check("to_err_sticky", {31'd0, fetch_err}, 32'd1);
      check("to_valid_sticky", {31'd0, instr_valid}, 32'd0);
      check("to_req_sticky", {31'd0, imem_req}, 32'd0);
      do_reset();

      // Misaligned redirect
      issue(0, $urandom);
      retire(0, 1'b0, 32'h0);
      issue(0, $urandom);
      redirect = 1'b1;
      redirect_target = 32'h0000_0102;
      @(negedge clk);
      redirect = 1'b0;
      check("mis_err", {31'd0, fetch_err}, 32'd1);
      check("mis_pc", pc, m_pc);
      check("mis_count", 32'(retire_count), 32'(m_cnt % (1 << CNT_W)));
      check("mis_valid", {31'd0, instr_valid}, 32'd0);
      check("mis_req", {31'd0, imem_req}, 32'd0);
      do_reset();

      // Reset mid-REQ followed by a late ack
      issue(0, $urandom);
      retire(0, 1'b1, 32'h0000_2000);
      wait_req(ok);
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_pc", pc, RESET_PC);
      check("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
      check("mid_rst_req", {31'd0, imem_req}, 32'd0);
      reset = 1'b0;
      imem_ack = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      sb.delete();
      m_pc = RESET_PC;
      m_cnt = 0;
      @(negedge clk);
      imem_ack = 1'b0;
      check("late_ack_valid", {31'd0, instr_valid}, 32'd0);
      check("late_ack_instr", instr, NOP);
      check("late_ack_req", {31'd0, imem_req}, 32'd1);

      // 16 retires wrap the 4-bit counter
      for (int i = 0; i < 16; i++) rand_fetch();
      check("count_wrap", 32'(retire_count), 32'd0);
      for (int i = 0; i < 20; i++) rand_fetch();

      check("sb_empty", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
